link_stack: RTL and testbench

- Hardware return-address stack: the consumer side of the link register.
- The call path pushes the link address; the return path pops it and gets a registered return address for the PC mux.
- Supports nested calls beyond the single link register.
- Overflow and underflow are reported through sticky error flags for the control unit.

---
 rtl/link_stack_pkg.sv | 28 ++
 rtl/link_stack_if.sv | 42 ++++
 rtl/link_stack_mem.sv | 41 ++++
 rtl/link_stack.sv | 147 ++++++++++++++
 tb/tb_link_stack.sv | 193 +++++++++++++++++++
 5 files changed

// File: rtl/link_stack_pkg.sv
`default_nettype none
// ============================================================================
// Module      : link_pkg
// Description : Shared types and constants for the link_stack return-address
//               stack: default address width, count-width helper, reset value
//               and the push/pop operation encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package link_pkg;

    localparam int ADDR_W     = 8;
    localparam int LR_RST_VAL = 0;

    // {pop, push} packed into a two-bit operation code.
    typedef enum logic [1:0] {
        OP_NONE = 2'b00,
        OP_PUSH = 2'b01,
        OP_POP  = 2'b10,
        OP_SWAP = 2'b11   // simultaneous push+pop: tail call
    } op_e;

    // Count must represent 0..DEPTH inclusive, hence one extra bit.
    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/link_stack_if.sv
`default_nettype none
// ============================================================================
// Module      : link_stack_if
// Description : Call/return bus of the link stack.
//               master : drives push/push_addr/pop/clr_err, observes status.
//               slave  : the stack itself.
//               Status: top, ret_addr, ret_valid, count, empty, full, ovf, unf.
// Revision    : 1.0 - initial release
// ============================================================================
interface link_stack_if
    import link_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int AW    = ADDR_W
);
    localparam int CW = cnt_w(DEPTH);

    logic          push;
    logic [AW-1:0] push_addr;
    logic          pop;
    logic          clr_err;
    logic [AW-1:0] top;
    logic [AW-1:0] ret_addr;
    logic          ret_valid;
    logic [CW-1:0] count;
    logic          empty;
    logic          full;
    logic          ovf;
    logic          unf;

    modport master (
        output push, push_addr, pop, clr_err,
        input  top, ret_addr, ret_valid, count, empty, full, ovf, unf
    );

    modport slave (
        input  push, push_addr, pop, clr_err,
        output top, ret_addr, ret_valid, count, empty, full, ovf, unf
    );

endinterface
`default_nettype wire

// File: rtl/link_stack_mem.sv
`default_nettype none
// ============================================================================
// Module      : link_stack_mem
// Description : DEPTH x AW register array, one synchronous write port and one
//               asynchronous read port, cleared by the active-low reset.
//   clk, rst             : clock, async active-low clear
//   we_i/waddr_i/wdata_i : write port
//   raddr_i/rdata_o      : combinational read port
// Revision    : 1.0 - initial release
// ============================================================================
module link_stack_mem
    import link_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int AW    = ADDR_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     we_i,
    input  logic [$clog2(DEPTH)-1:0] waddr_i,
    input  logic [AW-1:0]            wdata_i,
    input  logic [$clog2(DEPTH)-1:0] raddr_i,
    output logic [AW-1:0]            rdata_o
);

    logic [AW-1:0] mem_q [DEPTH];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= AW'(LR_RST_VAL);
            end
        end else if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule
`default_nettype wire

// File: rtl/link_stack.sv
`default_nettype none
// ============================================================================
// Module      : link_stack
// Description : Hardware return-address stack. Push stores a link address,
//               pop returns the top entry through a registered ret_addr with
//               a one-cycle ret_valid pulse. Sticky ovf/unf error flags.
//   clk : system clock
//   rst : asynchronous active-low reset
//   bus : link_stack_if.slave (push, push_addr, pop, clr_err in;
//         top, ret_addr, ret_valid, count, empty, full, ovf, unf out)
// Revision    : 1.0 - initial release
// ============================================================================
module link_stack
    import link_pkg::*;
#(
    parameter int DEPTH        = 8,
    parameter int AW           = ADDR_W,
    parameter bit WRAP_ON_FULL = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    link_stack_if.slave  bus
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = cnt_w(DEPTH);

    logic [PW-1:0] head_q, head_d;
    logic [CW-1:0] count_q, count_d;
    logic [AW-1:0] ret_addr_q, ret_addr_d;
    logic          ret_valid_q, ret_valid_d;
    logic          ovf_q, ovf_d;
    logic          unf_q, unf_d;

    logic          mem_we;
    logic [PW-1:0] mem_waddr;
    logic [PW-1:0] top_idx;
    logic [AW-1:0] mem_rdata;
    logic [AW-1:0] top_val;
    logic          is_empty;
    logic          is_full;
    op_e           op;

    // head points at the next free slot; the top lives one below it and the
    // PW-bit subtraction wraps naturally because DEPTH is a power of two.
    assign top_idx  = head_q - 1'b1;
    assign is_empty = (count_q == '0);
    assign is_full  = (count_q == CW'(DEPTH));
    assign top_val  = is_empty ? AW'(LR_RST_VAL) : mem_rdata;
    assign op       = op_e'({bus.pop, bus.push});

    link_stack_mem #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk     (clk),
        .rst     (rst),
        .we_i    (mem_we),
        .waddr_i (mem_waddr),
        .wdata_i (bus.push_addr),
        .raddr_i (top_idx),
        .rdata_o (mem_rdata)
    );

    always_comb begin
        head_d      = head_q;
        count_d     = count_q;
        ret_addr_d  = ret_addr_q;
        ret_valid_d = 1'b0;
        // Clear first so a same-cycle error below re-sets the flag.
        ovf_d       = ovf_q & ~bus.clr_err;
        unf_d       = unf_q & ~bus.clr_err;
        mem_we      = 1'b0;
        mem_waddr   = head_q;

        unique case (op)
            OP_PUSH: begin
                if (!is_full) begin
                    mem_we  = 1'b1;
                    head_d  = head_q + 1'b1;
                    count_d = count_q + 1'b1;
                end else begin
                    ovf_d = 1'b1;
                    // Circular mode: writing at head overwrites the oldest.
                    if (WRAP_ON_FULL) begin
                        mem_we = 1'b1;
                        head_d = head_q + 1'b1;
                    end
                end
            end
            OP_POP: begin
                if (!is_empty) begin
                    ret_addr_d  = top_val;
                    ret_valid_d = 1'b1;
                    head_d      = head_q - 1'b1;
                    count_d     = count_q - 1'b1;
                end else begin
                    unf_d = 1'b1;
                end
            end
            OP_SWAP: begin
                if (!is_empty) begin
                    // Tail call: replace the top in place, depth unchanged.
                    ret_addr_d  = top_val;
                    ret_valid_d = 1'b1;
                    mem_we      = 1'b1;
                    mem_waddr   = top_idx;
                end else begin
                    unf_d   = 1'b1;
                    mem_we  = 1'b1;
                    head_d  = head_q + 1'b1;
                    count_d = count_q + 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_q      <= '0;
            count_q     <= '0;
            ret_addr_q  <= AW'(LR_RST_VAL);
            ret_valid_q <= 1'b0;
            ovf_q       <= 1'b0;
            unf_q       <= 1'b0;
        end else begin
            head_q      <= head_d;
            count_q     <= count_d;
            ret_addr_q  <= ret_addr_d;
            ret_valid_q <= ret_valid_d;
            ovf_q       <= ovf_d;
            unf_q       <= unf_d;
        end
    end

    assign bus.top       = top_val;
    assign bus.ret_addr  = ret_addr_q;
    assign bus.ret_valid = ret_valid_q;
    assign bus.count     = count_q;
    assign bus.empty     = is_empty;
    assign bus.full      = is_full;
    assign bus.ovf       = ovf_q;
    assign bus.unf       = unf_q;

endmodule
`default_nettype wire

// File: tb/tb_link_stack.sv
`default_nettype none
// ============================================================================
// Module      : tb_link_stack
// Description : Self-checking bench for link_stack (DEPTH=4). Two instances,
//               WRAP_ON_FULL=1 (index 0) and WRAP_ON_FULL=0 (index 1), receive
//               identical stimulus and are compared against a queue model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_link_stack;

    localparam int DEPTH = 4;
    localparam int AW    = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    link_stack_if #(.DEPTH(DEPTH), .AW(AW)) bus0 ();
    link_stack_if #(.DEPTH(DEPTH), .AW(AW)) bus1 ();

    link_stack #(.DEPTH(DEPTH), .AW(AW), .WRAP_ON_FULL(1'b1)) u_dut0 (
        .clk (clk), .rst (rst), .bus (bus0.slave)
    );
    link_stack #(.DEPTH(DEPTH), .AW(AW), .WRAP_ON_FULL(1'b0)) u_dut1 (
        .clk (clk), .rst (rst), .bus (bus1.slave)
    );

    // Reference model: the stack is a queue, newest entry at the back.
    logic [AW-1:0] mq [2][$];
    logic          e_ovf [2];
    logic          e_unf [2];
    logic          e_rv  [2];
    logic [AW-1:0] e_ra  [2];

    int total  = 0;
    int passed = 0;

    task automatic chk(input string tag, input int m, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s[dut%0d]: observed %0h expected %0h", tag, m, obs, exp);
    endtask

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            mq[m].delete();
            e_ovf[m] = 1'b0;
            e_unf[m] = 1'b0;
            e_rv[m]  = 1'b0;
            e_ra[m]  = '0;
        end
    endtask

    task automatic model_step(input logic p, input logic [AW-1:0] a, input logic q, input logic c);
        for (int m = 0; m < 2; m++) begin
            int sz = mq[m].size();
            e_rv[m] = 1'b0;
            if (c) begin
                e_ovf[m] = 1'b0;
                e_unf[m] = 1'b0;
            end
            if (p && q) begin
                if (sz > 0) begin
                    e_ra[m] = mq[m][sz-1];
                    e_rv[m] = 1'b1;
                    mq[m][sz-1] = a;
                end else begin
                    e_unf[m] = 1'b1;
                    mq[m].push_back(a);
                end
            end else if (p) begin
                if (sz < DEPTH) begin
                    mq[m].push_back(a);
                end else begin
                    e_ovf[m] = 1'b1;
                    if (m == 0) begin
                        void'(mq[m].pop_front());
                        mq[m].push_back(a);
                    end
                end
            end else if (q) begin
                if (sz > 0) begin
                    e_ra[m] = mq[m].pop_back();
                    e_rv[m] = 1'b1;
                end else begin
                    e_unf[m] = 1'b1;
                end
            end
        end
    endtask

    task automatic check_all(input string tag);
        for (int m = 0; m < 2; m++) begin
            int sz = mq[m].size();
            logic [AW-1:0] etop;
            etop = (sz > 0) ? mq[m][sz-1] : '0;
            chk({tag, ".top"},       m, 32'((m == 0) ? bus0.top       : bus1.top),       32'(etop));
            chk({tag, ".count"},     m, 32'((m == 0) ? bus0.count     : bus1.count),     32'(sz));
            chk({tag, ".empty"},     m, 32'((m == 0) ? bus0.empty     : bus1.empty),     32'(sz == 0));
            chk({tag, ".full"},      m, 32'((m == 0) ? bus0.full      : bus1.full),      32'(sz == DEPTH));
            chk({tag, ".ovf"},       m, 32'((m == 0) ? bus0.ovf       : bus1.ovf),       32'(e_ovf[m]));
            chk({tag, ".unf"},       m, 32'((m == 0) ? bus0.unf       : bus1.unf),       32'(e_unf[m]));
            chk({tag, ".ret_valid"}, m, 32'((m == 0) ? bus0.ret_valid : bus1.ret_valid), 32'(e_rv[m]));
            chk({tag, ".ret_addr"},  m, 32'((m == 0) ? bus0.ret_addr  : bus1.ret_addr),  32'(e_ra[m]));
        end
    endtask

    task automatic drive(input logic p, input logic [AW-1:0] a, input logic q, input logic c);
        bus0.push = p; bus0.push_addr = a; bus0.pop = q; bus0.clr_err = c;
        bus1.push = p; bus1.push_addr = a; bus1.pop = q; bus1.clr_err = c;
    endtask

    task automatic step(input string tag, input logic p, input logic [AW-1:0] a,
                        input logic q, input logic c);
        drive(p, a, q, c);
        model_step(p, a, q, c);
        @(posedge clk);
        #1;
        check_all(tag);
        drive(1'b0, '0, 1'b0, 1'b0);
    endtask

    initial begin
        drive(1'b0, '0, 1'b0, 1'b0);
        model_reset();
        #12;
        check_all("reset");
        @(negedge clk);
        rst = 1'b1;

        // Basic LIFO order.
        step("push0F", 1, 8'h0F, 0, 0);
        step("push1E", 1, 8'h1E, 0, 0);
        step("push2D", 1, 8'h2D, 0, 0);
        chk("plan.top2D", 0, 32'(bus0.top), 32'h2D);
        step("pop1", 0, 0, 1, 0);
        chk("plan.ret2D", 0, 32'(bus0.ret_addr), 32'h2D);
        step("pop2", 0, 0, 1, 0);
        step("pop3", 0, 0, 1, 0);
        chk("plan.ret0F", 1, 32'(bus1.ret_addr), 32'h0F);
        step("idle", 0, 0, 0, 0);

        // Underflow and sticky clear.
        step("pop_empty", 0, 0, 1, 0);
        chk("plan.unf", 0, 32'(bus0.unf), 32'h1);
        step("clr_err", 0, 0, 0, 1);
        step("pop_clr", 0, 0, 1, 1);
        chk("plan.unf_set_wins", 1, 32'(bus1.unf), 32'h1);
        step("clr_err2", 0, 0, 0, 1);

        // Overflow: wrap vs drop.
        for (int i = 1; i <= 5; i++) step("ovf_push", 1, 8'(i), 0, 0);
        chk("plan.wrap_top", 0, 32'(bus0.top), 32'h05);
        chk("plan.drop_top", 1, 32'(bus1.top), 32'h04);
        for (int i = 0; i < 4; i++) step("ovf_pop", 0, 0, 1, 0);
        step("clr_ovf", 0, 0, 0, 1);

        // Tail call, then tail call while full.
        step("pushAA", 1, 8'hAA, 0, 0);
        step("swapF0", 1, 8'hF0, 1, 0);
        chk("plan.swap_ret", 0, 32'(bus0.ret_addr), 32'hAA);
        for (int i = 0; i < 3; i++) step("fill", 1, 8'h50 + 8'(i), 0, 0);
        step("swap_full", 1, 8'h77, 1, 0);
        chk("plan.swap_no_ovf", 1, 32'(bus1.ovf), 32'h0);

        // Asynchronous reset between edges.
        step("push33a", 1, 8'h33, 0, 0);
        step("push33b", 1, 8'h33, 0, 0);
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        check_all("async_rst");
        #1;
        rst = 1'b1;
        step("push44", 1, 8'h44, 0, 0);
        chk("plan.post_rst_top", 0, 32'(bus0.top), 32'h44);

        // Randomized traffic.
        for (int n = 0; n < 400; n++) begin
            logic p, q, c;
            p = ($urandom_range(0, 99) < 55);
            q = ($urandom_range(0, 99) < 45);
            c = ($urandom_range(0, 99) < 10);
            step("rand", p, 8'($urandom), q, c);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire
